// File: rtl/div_sequencer.sv
// div_sequencer: issue stage in front of the shift/add divider controller.
// It accepts an operand pair, holds it for the datapath, pulses start, and
// waits for the controller's done. It then returns the quotient and remainder
// over a valid/ready handshake. A watchdog turns a missing done into a
// timeout response.
// Optional build macro: DIV_SEQ_ZERO_BYPASS_EN. When it is defined, a zero
// divisor is answered directly without running the divider.

module div_sequencer #(
    parameter int WIDTH          = 8,
    parameter int START_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic [WIDTH-1:0] op_dividend,
    output logic [WIDTH-1:0] op_divisor,
    output logic             start,
    input  logic             done,
    input  logic [WIDTH-1:0] dp_quotient,
    input  logic [WIDTH-1:0] dp_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_divzero,
    output logic             out_timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // The last count value of each phase. The counters start at zero on entry.
    localparam logic [3:0] START_LAST = 4'(START_CYCLES - 1);
    localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT_CYCLES - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [3:0]       start_cnt_r;
    logic [7:0]       wdog_r;
    logic [WIDTH-1:0] op_dividend_r;
    logic [WIDTH-1:0] op_divisor_r;
    logic [WIDTH-1:0] out_quotient_r;
    logic [WIDTH-1:0] out_remainder_r;
    logic             out_divzero_r;
    logic             out_timeout_r;

    logic             accept_s;
    logic             zero_div_s;
    logic             start_last_s;
    logic             wdog_last_s;
    logic             in_ready_s;
    logic             start_s;
    logic             out_valid_s;
    logic             busy_s;

    // Qualifiers shared by the FSM and the datapath registers.
    always_comb begin
        accept_s     = in_valid && (state_r == ST_IDLE);
        start_last_s = (start_cnt_r == START_LAST);
        wdog_last_s  = (wdog_r == WDOG_LAST);
`ifdef DIV_SEQ_ZERO_BYPASS_EN
        zero_div_s   = (in_divisor == {WIDTH{1'b0}});
`else
        zero_div_s   = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic. A done on the final watchdog cycle wins over the timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (zero_div_s) begin
                        next_state_s = ST_RESP;
                    end else begin
                        next_state_s = ST_START;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (start_last_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_RUN: begin
                if (done || wdog_last_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Handshake and control outputs, decoded only from registered state.
    always_comb begin
        in_ready_s  = 1'b0;
        start_s     = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            ST_START: begin
                start_s = 1'b1;
            end
            ST_RUN: begin
                start_s = 1'b0;
            end
            ST_RESP: begin
                out_valid_s = 1'b1;
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    // Start-length counter and RUN watchdog. Each is cleared on entry to its phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_cnt_r <= 4'd0;
            wdog_r      <= 8'd0;
        end else begin
            if (accept_s) begin
                start_cnt_r <= 4'd0;
            end else if ((state_r == ST_START) && !start_last_s) begin
                start_cnt_r <= start_cnt_r + 4'd1;
            end else begin
                start_cnt_r <= start_cnt_r;
            end

            if ((state_r == ST_START) && start_last_s) begin
                wdog_r <= 8'd0;
            end else if (state_r == ST_RUN) begin
                wdog_r <= wdog_r + 8'd1;
            end else begin
                wdog_r <= wdog_r;
            end
        end
    end

    // Operand latch on accept; result capture on done or watchdog expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_dividend_r   <= {WIDTH{1'b0}};
            op_divisor_r    <= {WIDTH{1'b0}};
            out_quotient_r  <= {WIDTH{1'b0}};
            out_remainder_r <= {WIDTH{1'b0}};
            out_divzero_r   <= 1'b0;
            out_timeout_r   <= 1'b0;
        end else if (accept_s) begin
            op_dividend_r <= in_dividend;
            op_divisor_r  <= in_divisor;
            out_timeout_r <= 1'b0;
            if (zero_div_s) begin
                out_divzero_r   <= 1'b1;
                out_quotient_r  <= {WIDTH{1'b1}};
                out_remainder_r <= in_dividend;
            end else begin
                out_divzero_r <= 1'b0;
            end
        end else if (state_r == ST_RUN) begin
            if (done) begin
                out_quotient_r  <= dp_quotient;
                out_remainder_r <= dp_remainder;
            end else if (wdog_last_s) begin
                out_timeout_r   <= 1'b1;
                out_quotient_r  <= {WIDTH{1'b0}};
                out_remainder_r <= {WIDTH{1'b0}};
            end else begin
                out_quotient_r  <= out_quotient_r;
                out_remainder_r <= out_remainder_r;
            end
        end else begin
            op_dividend_r <= op_dividend_r;
            op_divisor_r  <= op_divisor_r;
        end
    end

    assign in_ready      = in_ready_s;
    assign start         = start_s;
    assign out_valid     = out_valid_s;
    assign busy          = busy_s;
    assign op_dividend   = op_dividend_r;
    assign op_divisor    = op_divisor_r;
    assign out_quotient  = out_quotient_r;
    assign out_remainder = out_remainder_r;
    assign out_divzero   = out_divzero_r;
    assign out_timeout   = out_timeout_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer. The bench plays the divider
// controller and the consumer. Expected responses come from a
// transaction-level model: result values come from plain division. The
// response cycle comes from the latency rule, counted from the accept cycle.

module tb_div_sequencer;

    localparam int WIDTH = 8;
    localparam int SC    = 3;
    localparam int TO    = 24;
`ifdef DIV_SEQ_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic [WIDTH-1:0] op_dividend;
    logic [WIDTH-1:0] op_divisor;
    logic             start;
    logic             done;
    logic [WIDTH-1:0] dp_quotient;
    logic [WIDTH-1:0] dp_remainder;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             out_divzero;
    logic             out_timeout;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_sequencer #(
        .WIDTH(WIDTH),
        .START_CYCLES(SC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_dividend(in_dividend),
        .in_divisor(in_divisor),
        .op_dividend(op_dividend),
        .op_divisor(op_divisor),
        .start(start),
        .done(done),
        .dp_quotient(dp_quotient),
        .dp_remainder(dp_remainder),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_quotient(out_quotient),
        .out_remainder(out_remainder),
        .out_divzero(out_divzero),
        .out_timeout(out_timeout),
        .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The result a real shift/add divider would produce.
    function automatic logic [15:0] ref_div(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q;
        logic [7:0] r;
        if (b == 8'd0) begin
            q = 8'hFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_start"}, start, 0);
    endtask

    // One operation. d is the RUN cycle on which the controller raises done.
    // d=0 means the controller never raises done. bp is the number of extra
    // cycles that out_ready stays low. early adds a stray done inside START.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int d,
                           input int bp, input bit early);
        bit         byp;
        bit         tmo;
        int         lat;
        logic [7:0] eq;
        logic [7:0] er;
        logic [15:0] res;
        bit         edz;
        bit         eto;
        res = ref_div(a, b);
        byp = BYPASS && (b == 8'd0);
        tmo = !byp && (d == 0 || d > TO);
        if (byp) begin
            lat = 1; eq = 8'hFF; er = a; edz = 1'b1; eto = 1'b0;
        end else if (tmo) begin
            lat = 1 + SC + TO; eq = 8'd0; er = 8'd0; edz = 1'b0; eto = 1'b1;
        end else begin
            lat = 1 + SC + d; eq = res[15:8]; er = res[7:0]; edz = 1'b0; eto = 1'b0;
        end

        check_idle("idle");
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        done        = 1'b0;
        out_ready   = 1'b0;
        @(negedge clk);
        for (int cyc = 1; cyc <= lat + bp; cyc++) begin
            in_valid     = 1'($urandom_range(0, 1));
            in_dividend  = 8'($urandom);
            in_divisor   = 8'($urandom);
            dp_quotient  = 8'($urandom);
            dp_remainder = 8'($urandom);
            done         = 1'b0;
            if (!byp && d > 0 && cyc == SC + d) begin
                done         = 1'b1;
                dp_quotient  = res[15:8];
                dp_remainder = res[7:0];
            end else if (early && cyc == 2) begin
                done = 1'b1;
            end else if (cyc >= lat && $urandom_range(0, 1) == 1) begin
                done = 1'b1;
            end else begin
                done = 1'b0;
            end
            out_ready = (cyc == lat + bp);

            check_eq("start", start, (!byp && cyc <= SC) ? 1 : 0);
            check_eq("out_valid", out_valid, (cyc >= lat) ? 1 : 0);
            check_eq("in_ready_busy", in_ready, 0);
            check_eq("busy", busy, 1);
            check_eq("op_dividend", op_dividend, a);
            check_eq("op_divisor", op_divisor, b);
            if (cyc >= lat) begin
                check_eq("out_quotient", out_quotient, eq);
                check_eq("out_remainder", out_remainder, er);
                check_eq("out_divzero", out_divzero, edz);
                check_eq("out_timeout", out_timeout, eto);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        done      = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_dividend  = 8'd0;
        in_divisor   = 8'd0;
        done         = 1'b0;
        dp_quotient  = 8'd0;
        dp_remainder = 8'd0;
        out_ready    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // State immediately after reset.
        check_idle("rst");
        check_eq("rst_op_dividend", op_dividend, 0);
        check_eq("rst_op_divisor", op_divisor, 0);
        check_eq("rst_out_q", out_quotient, 0);
        check_eq("rst_out_r", out_remainder, 0);
        check_eq("rst_divzero", out_divzero, 0);
        check_eq("rst_timeout", out_timeout, 0);

        // Directed operations.
        run_txn(8'd100, 8'd7, 18, 0, 1'b0);
        run_txn(8'd200, 8'd9, 5, 5, 1'b0);
        run_txn(8'd77, 8'd3, 0, 2, 1'b0);
        run_txn(8'd250, 8'd16, TO, 0, 1'b0);
        run_txn(8'd55, 8'd0, 10, 1, 1'b0);
        run_txn(8'd123, 8'd10, 7, 1, 1'b1);
        run_txn(8'd1, 8'd1, 1, 0, 1'b0);

        // Reset in the middle of RUN abandons the operation.
        in_valid    = 1'b1;
        in_dividend = 8'd9;
        in_divisor  = 8'd2;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (SC + 3) @(negedge clk);
        check_eq("mid_busy", busy, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_idle("midrst");
        check_eq("midrst_op_dividend", op_dividend, 0);
        check_eq("midrst_out_q", out_quotient, 0);
        check_eq("midrst_out_r", out_remainder, 0);
        for (int i = 0; i < 4; i++) begin
            done         = 1'b1;
            dp_quotient  = 8'd4;
            dp_remainder = 8'd1;
            @(negedge clk);
            check_idle("midrst_done");
            check_eq("midrst_out_q_hold", out_quotient, 0);
        end
        done = 1'b0;

        // Randomized operations.
        for (int t = 0; t < 40; t++) begin
            logic [7:0] a;
            logic [7:0] b;
            int         d;
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            d = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO + 3));
            run_txn(a, b, d, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        check_idle("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Front-end issue stage for the shift/add divider; sits directly upstream of the divider controller and its datapath.
- Accepts an operand pair over a valid/ready handshake and holds the operands stable for the datapath.
- Drives the controller's start input, then waits for the controller's valid pulse.
- Captures quotient/remainder from the datapath and returns them over a second valid/ready handshake, with a watchdog for a missing completion.

Parameters:
WIDTH, 8, operand/result width in bits.
START_CYCLES, 1, number of cycles start is held high per operation (1..15).
TIMEOUT_CYCLES, 24, RUN cycles allowed before a missing done is flagged (must exceed the controller's 18-cycle latency; 1..255).

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair offered.
in_ready  output  1  sequencer can accept operands.
in_dividend  input  WIDTH  dividend.
in_divisor  input  WIDTH  divisor.
op_dividend  output  WIDTH  registered dividend to datapath, stable from accept until next accept.
op_divisor  output  WIDTH  registered divisor to datapath, same stability.
start  output  1  start to controller.
done  input  1  controller valid (completion pulse).
dp_quotient  input  WIDTH  datapath quotient.
dp_remainder  input  WIDTH  datapath remainder.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_quotient  output  WIDTH  registered quotient.
out_remainder  output  WIDTH  registered remainder.
out_divzero  output  1  result is a divide-by-zero response.
out_timeout  output  1  result is a watchdog response.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). The polarity and synchronicity are fixed.
- Reset, sampled on clk:
  - State goes to IDLE.
  - op_*, out_quotient, out_remainder, out_divzero, out_timeout, and the start/watchdog counters clear to 0.
  - In the first cycle after reset: in_ready=1, start=0, out_valid=0, busy=0.
  - Reset mid-operation abandons the operation with no response.
- States (2-bit encoding): IDLE=0, START=1, RUN=2, RESP=3. in_ready=(state==IDLE), start=(state==START), out_valid=(state==RESP). All are decoded from registered state, with no combinational path from inputs.
- IDLE:
  - On in_valid&in_ready, latch in_dividend/in_divisor into op_* and clear out_divzero/out_timeout.
  - Next state is START, or RESP under the divide-by-zero rule in Optional Feature.
  - in_valid low: stay in IDLE.
- START:
  - start=1 for exactly START_CYCLES consecutive cycles, counted by a 4-bit counter cleared on entry.
  - Then go to RUN; the watchdog is cleared on entry to RUN.
  - done asserted during START is ignored.
- RUN:
  - start=0; the 8-bit watchdog increments each cycle.
  - done=1: capture dp_quotient/dp_remainder into out_* in the same edge, then go to RESP.
  - Watchdog reaches TIMEOUT_CYCLES-1 with done=0: out_timeout=1, out_quotient=0, out_remainder=0, go to RESP.
  - done on the final watchdog cycle wins over timeout.
- RESP:
  - out_* are held stable while out_valid=1 and out_ready=0.
  - On out_ready=1, go to IDLE at the next edge.
  - in_ready=0; there is no accept in the same cycle as the response handshake.
  - done is ignored.
- in_valid is ignored outside IDLE. op_* hold their values until the next accept.
- Latency for a nonzero divisor, with done arriving D cycles after START exit (D>=1): accept edge to out_valid = 1 + START_CYCLES + D cycles.

Optional Feature:
- Macro DIV_SEQ_ZERO_BYPASS_EN.
- Defined: on accept with in_divisor==0, go IDLE->RESP directly. start is never asserted. out_divzero=1, out_quotient = all ones, out_remainder = in_dividend, and out_valid rises on the cycle after accept.
- Undefined: a zero divisor follows the normal START/RUN path, datapath results are returned unmodified, and out_divzero stays 0.

Test Plan:
- Reset held 2 cycles in the middle of RUN -> next cycle in_ready=1, busy=0, out_valid=0, start=0, out_* = 0; later done pulses produce no response.
- Accept 100/7, START_CYCLES=1, model asserts done 18 cycles after START exit with dp=14/2 -> start high exactly 1 cycle; out_valid at accept+20 with 14/2; out_divzero=0, out_timeout=0.
- Response backpressure: out_ready low 5 cycles, in_valid held high with new operands -> out_* stable, in_ready=0 throughout; after out_ready pulse, IDLE, then the new operands are accepted next cycle.
- Missing done, TIMEOUT_CYCLES=24 -> out_valid after 24 RUN cycles with out_timeout=1, out_quotient=0, out_remainder=0; a done pulse during RESP is ignored.
- DIV_SEQ_ZERO_BYPASS_EN defined, accept 55/0 -> start never high; next cycle out_valid=1, quotient=8'hFF, remainder=55, out_divzero=1. Undefined -> normal START/RUN sequence with out_divzero=0.
- START_CYCLES=3 with done asserted during START -> start high 3 cycles and the early done is ignored; the subsequent done in RUN is captured correctly.
